board_update_arbiter: RTL

- Shares the single write port of the backgammon board-state RAM (26 entries: 24 points, bar, home; 8-bit cell) among NREQ requesters (button handler, dice roller, move engine, score logic).
- Grants writes only during vertical blanking, so the VGA renderer never reads a half-updated board mid-frame.
- Grants are round-robin, one per cycle, with a per-frame write budget.
- Sits between the game-logic requesters and the board RAM. Watches vCount from display_controller.

---
 rtl/board_update_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/board_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : board_update_arbiter
// Purpose  : Shares the single write port of the backgammon board-state RAM
//            among NREQ requesters. Writes are granted only during vertical
//            blanking, so the renderer never sees a half-updated board. Grants
//            are round-robin, at most one per cycle, with a per-window budget.
// Ports    : clk         system clock
//            reset_n     synchronous active-low reset
//            vCount      current display line
//            req         per-requester level write request
//            req_addr    flattened 5-bit addresses, requester i at [5i+4:5i]
//            req_data    flattened 8-bit data, requester i at [8i+7:8i]
//            grant       one-hot, single-cycle grant pulse
//            wr_en       board RAM write enable (equals |grant)
//            wr_addr     board RAM address
//            wr_data     board RAM data
//            frame_tick  single-cycle pulse when a blanking window opens
//            in_window   high while a blanking window is being served
//            stall_count (STALL_COUNT_EN only) windows closed with work left
// Options  : define STALL_COUNT_EN to add the stall_count output.
// Revision : 1.0 - initial release
// ============================================================================
module board_update_arbiter #(
    parameter int NREQ      = 4,
    parameter int VB_START  = 515,
    parameter int VB_END    = 35,
    parameter int WR_BUDGET = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        vCount,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*5-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_tick,
    output logic              in_window
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int         c_PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         c_IDX_W    = c_PTR_W + 1;
    localparam logic [9:0] c_VB_START = 10'(VB_START);
    localparam logic [9:0] c_VB_END   = 10'(VB_END);
    localparam logic [7:0] c_BUDGET   = 8'(WR_BUDGET);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARB  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    logic [1:0]         r_state;
    logic [c_PTR_W-1:0] r_rrPtr;
    logic [7:0]         r_count;
    logic               r_blankQ;
    logic               r_blankQQ;

    logic               w_blankNow;
    logic               w_rise;
    logic [NREQ-1:0]    w_eligible;
    logic               w_found;
    logic [c_PTR_W-1:0] w_sel;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_PTR_W-1:0] w_nextPtr;
    logic [NREQ-1:0]    w_onehot;
    logic [4:0]         w_addrArr [NREQ];
    logic [7:0]         w_dataArr [NREQ];

    // Blanking wraps through the end of the frame back to line 0.
    assign w_blankNow = (vCount >= c_VB_START) || (vCount < c_VB_END);
    assign w_rise     = r_blankQ & ~r_blankQQ;

    // A requester still holding req during its own grant cycle must not be
    // granted again for the same item.
    assign w_eligible = req & ~grant;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addrArr[gi] = req_addr[5*gi +: 5];
            assign w_dataArr[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // First eligible requester scanning upward from r_rrPtr, modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rrPtr} + c_IDX_W'(k);
            if (w_idx >= c_IDX_W'(NREQ)) begin
                w_idx = w_idx - c_IDX_W'(NREQ);
            end
            if (!w_found && w_eligible[w_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[c_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_sel] = 1'b1;
    end

    assign w_nextPtr = (w_sel == c_PTR_W'(NREQ - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_rrPtr    <= '0;
            r_count    <= '0;
            r_blankQ   <= 1'b0;
            r_blankQQ  <= 1'b0;
            grant      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_tick <= 1'b0;
            in_window  <= 1'b0;
        end else begin
            r_blankQ   <= w_blankNow;
            r_blankQQ  <= r_blankQ;
            frame_tick <= 1'b0;
            grant      <= '0;
            wr_en      <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_rise) begin
                        r_state    <= c_ARB;
                        frame_tick <= 1'b1;
                        r_count    <= '0;
                        in_window  <= 1'b1;
                    end
                end
                c_ARB: begin
                    if (!r_blankQ) begin
                        r_state   <= c_IDLE;
                        in_window <= 1'b0;
                    end else if (r_count == c_BUDGET) begin
                        r_state <= c_HOLD;
                    end else if (w_found) begin
                        grant   <= w_onehot;
                        wr_en   <= 1'b1;
                        wr_addr <= w_addrArr[w_sel];
                        wr_data <= w_dataArr[w_sel];
                        r_count <= r_count + 8'd1;
                        r_rrPtr <= w_nextPtr;
                    end
                end
                c_HOLD: begin
                    if (!r_blankQ) begin
                        r_state   <= c_IDLE;
                        in_window <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    in_window <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_COUNT_EN
    logic w_close;

    // A window closing while someone still waits means that update slipped
    // a whole frame; count it, saturating.
    assign w_close = ((r_state == c_ARB) || (r_state == c_HOLD)) && !r_blankQ;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (w_close && (|(req & ~grant)) && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
